// File: rtl/alu_seq_pkg.sv
// Shared definitions for the two-pass 32-bit add/subtract sequencer:
// op codes, ALU select codes, FSM states and NZCV bit positions.
package alu_seq_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ALU_W  = 16;
    localparam int unsigned NZCV_W = 4;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_ADC = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;
    localparam logic [1:0] OP_SBC = 2'b11;

    localparam logic [1:0] S_ADD = 2'b00;
    localparam logic [1:0] S_ADC = 2'b01;
    localparam logic [1:0] S_SUB = 2'b10;
    localparam logic [1:0] S_SBC = 2'b11;

    localparam int unsigned NZCV_N = 3;
    localparam int unsigned NZCV_Z = 2;
    localparam int unsigned NZCV_C = 1;
    localparam int unsigned NZCV_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LO   = 2'b01,
        ST_HI   = 2'b10,
        ST_RESP = 2'b11
    } state_t;

    typedef struct packed {
        logic [1:0]        op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } req_t;

    // ALU select for the low pass.
    function automatic logic [1:0] lo_sel(input logic [1:0] op);
        logic [1:0] sel;
        sel = S_ADD;
        case (op)
            OP_ADD:  sel = S_ADD;
            OP_ADC:  sel = S_ADC;
            OP_SUB:  sel = S_SUB;
            default: sel = S_SBC;
        endcase
        return sel;
    endfunction

    // ALU select for the high pass: always the carry-consuming flavour.
    function automatic logic [1:0] hi_sel(input logic [1:0] op);
        return (op == OP_SUB || op == OP_SBC) ? S_SBC : S_ADC;
    endfunction

    function automatic logic uses_flag_c(input logic [1:0] op);
        return (op == OP_ADC || op == OP_SBC);
    endfunction

endpackage

// File: rtl/alu_seq32.sv
// Two-pass 32-bit add/subtract sequencer driving an external 16-bit ALU.
// Optional ALU_SEQ_SHORT16_EN adds req_w16 for single-pass 16-bit operations.
module alu_seq32
    import alu_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
`ifdef ALU_SEQ_SHORT16_EN
    input  logic              req_w16,
`endif
    output logic [ALU_W-1:0]  alu_a,
    output logic [ALU_W-1:0]  alu_b,
    output logic [1:0]        alu_s,
    output logic              alu_cin,
    input  logic [ALU_W-1:0]  alu_result,
    input  logic              alu_n,
    input  logic              alu_z,
    input  logic              alu_c,
    input  logic              alu_v,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic [NZCV_W-1:0] rsp_nzcv,
    output logic [NZCV_W-1:0] flags
);

    state_t             state, state_nxt;
    req_t               req_q, req_nxt;
    logic [ALU_W-1:0]   lo_res, lo_res_nxt;
    logic               lo_z, lo_z_nxt;
    logic               lo_c, lo_c_nxt;
    logic [DATA_W-1:0]  rsp_result_nxt;
    logic [NZCV_W-1:0]  rsp_nzcv_nxt;
    logic [NZCV_W-1:0]  flags_nxt;
    logic [ALU_W-1:0]   alu_a_nxt, alu_b_nxt;
    logic [1:0]         alu_s_nxt;
    logic               alu_cin_nxt;
    logic               req_ready_nxt;
    logic               rsp_valid_nxt;
`ifdef ALU_SEQ_SHORT16_EN
    logic               w16_q, w16_nxt;
`endif

    // Registers: state plus every output, so the ALU sees clean flop outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            req_q      <= '0;
            lo_res     <= '0;
            lo_z       <= 1'b0;
            lo_c       <= 1'b0;
            rsp_result <= '0;
            rsp_nzcv   <= '0;
            flags      <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_s      <= '0;
            alu_cin    <= 1'b0;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
`ifdef ALU_SEQ_SHORT16_EN
            w16_q      <= 1'b0;
`endif
        end else begin
            state      <= state_nxt;
            req_q      <= req_nxt;
            lo_res     <= lo_res_nxt;
            lo_z       <= lo_z_nxt;
            lo_c       <= lo_c_nxt;
            rsp_result <= rsp_result_nxt;
            rsp_nzcv   <= rsp_nzcv_nxt;
            flags      <= flags_nxt;
            alu_a      <= alu_a_nxt;
            alu_b      <= alu_b_nxt;
            alu_s      <= alu_s_nxt;
            alu_cin    <= alu_cin_nxt;
            req_ready  <= req_ready_nxt;
            rsp_valid  <= rsp_valid_nxt;
`ifdef ALU_SEQ_SHORT16_EN
            w16_q      <= w16_nxt;
`endif
        end
    end

    // Next state, captures, and the ALU drive for whichever pass is entered next.
    always_comb begin
        state_nxt      = state;
        req_nxt        = req_q;
        lo_res_nxt     = lo_res;
        lo_z_nxt       = lo_z;
        lo_c_nxt       = lo_c;
        rsp_result_nxt = rsp_result;
        rsp_nzcv_nxt   = rsp_nzcv;
        flags_nxt      = flags;
        alu_a_nxt      = '0;
        alu_b_nxt      = '0;
        alu_s_nxt      = '0;
        alu_cin_nxt    = 1'b0;
`ifdef ALU_SEQ_SHORT16_EN
        w16_nxt        = w16_q;
`endif

        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    req_nxt.op = req_op;
                    req_nxt.a  = req_a;
                    req_nxt.b  = req_b;
`ifdef ALU_SEQ_SHORT16_EN
                    w16_nxt    = req_w16;
`endif
                    state_nxt  = ST_LO;
                end
            end
            ST_LO: begin
                lo_res_nxt = alu_result;
                lo_z_nxt   = alu_z;
                lo_c_nxt   = alu_c;
                state_nxt  = ST_HI;
`ifdef ALU_SEQ_SHORT16_EN
                if (w16_q) begin
                    rsp_result_nxt = {{ALU_W{1'b0}}, alu_result};
                    rsp_nzcv_nxt   = {alu_n, alu_z, alu_c, alu_v};
                    flags_nxt      = {alu_n, alu_z, alu_c, alu_v};
                    state_nxt      = ST_RESP;
                end
`endif
            end
            ST_HI: begin
                rsp_result_nxt = {alu_result, lo_res};
                rsp_nzcv_nxt   = {alu_n, lo_z & alu_z, alu_c, alu_v};
                flags_nxt      = {alu_n, lo_z & alu_z, alu_c, alu_v};
                state_nxt      = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        // On accept req_nxt already holds the incoming operands.
        case (state_nxt)
            ST_LO: begin
                alu_a_nxt   = req_nxt.a[ALU_W-1:0];
                alu_b_nxt   = req_nxt.b[ALU_W-1:0];
                alu_s_nxt   = lo_sel(req_nxt.op);
                alu_cin_nxt = uses_flag_c(req_nxt.op) ? flags[NZCV_C] : 1'b0;
            end
            ST_HI: begin
                alu_a_nxt   = req_nxt.a[DATA_W-1:ALU_W];
                alu_b_nxt   = req_nxt.b[DATA_W-1:ALU_W];
                alu_s_nxt   = hi_sel(req_nxt.op);
                alu_cin_nxt = lo_c_nxt;
            end
            default: ;
        endcase

        req_ready_nxt = (state_nxt == ST_IDLE);
        rsp_valid_nxt = (state_nxt == ST_RESP);
    end

endmodule

// File: tb/tb_alu_seq32.sv
// Self-checking bench for alu_seq32: behavioural 16-bit ALU beside the DUT,
// 32-bit reference model for results/flags, directed cases then random ops.
module tb_alu_seq32;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_a, req_b;
    logic [15:0] alu_a, alu_b;
    logic [1:0]  alu_s;
    logic        alu_cin;
    logic [15:0] alu_result;
    logic        alu_n, alu_z, alu_c, alu_v;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic [3:0]  rsp_nzcv;
    logic [3:0]  flags;
`ifdef ALU_SEQ_SHORT16_EN
    logic        req_w16 = 1'b0;
`endif

    int compared   = 0;
    int mismatched = 0;
    logic [3:0] m_flags;

    always #5 clk = ~clk;

    alu_seq32 dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
`ifdef ALU_SEQ_SHORT16_EN
        .req_w16    (req_w16),
`endif
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_s      (alu_s),
        .alu_cin    (alu_cin),
        .alu_result (alu_result),
        .alu_n      (alu_n),
        .alu_z      (alu_z),
        .alu_c      (alu_c),
        .alu_v      (alu_v),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_nzcv   (rsp_nzcv),
        .flags      (flags)
    );

    // Behavioural 16-bit ALU: subtract forms add the inverted operand.
    logic [15:0] m_b;
    logic        m_ci;
    logic [16:0] m_sum;
    always_comb begin
        m_b  = alu_s[1] ? ~alu_b : alu_b;
        m_ci = 1'b0;
        case (alu_s)
            2'b00:   m_ci = 1'b0;
            2'b10:   m_ci = 1'b1;
            default: m_ci = alu_cin;
        endcase
        m_sum      = {1'b0, alu_a} + {1'b0, m_b} + 17'(m_ci);
        alu_result = m_sum[15:0];
        alu_c      = m_sum[16];
        alu_n      = m_sum[15];
        alu_z      = (m_sum[15:0] == 16'h0);
        alu_v      = (alu_a[15] == m_b[15]) && (m_sum[15] != alu_a[15]);
    end

    // Full-width reference: returns {result[31:0], N, Z, C, V}.
    function automatic logic [35:0] ref_op(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic cflag);
        logic [31:0] bb;
        logic        ci;
        logic [32:0] s;
        logic        v;
        bb = op[1] ? ~b : b;
        ci = op[0] ? cflag : op[1];
        s  = {1'b0, a} + {1'b0, bb} + 33'(ci);
        v  = (a[31] == bb[31]) && (s[31] != a[31]);
        return {s[31:0], s[31], (s[31:0] == 32'h0), s[32], v};
    endfunction

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int hold, input logic chk_lit, input logic [35:0] lit);
        logic [35:0] exp;
        logic [31:0] bb;
        logic        lo_ci;
        logic [16:0] lo_sum;
        int          n;
        exp    = ref_op(op, a, b, m_flags[1]);
        bb     = op[1] ? ~b : b;
        lo_ci  = op[0] ? m_flags[1] : op[1];
        lo_sum = {1'b0, a[15:0]} + {1'b0, bb[15:0]} + 17'(lo_ci);
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_idle", 96'(req_ready), 96'(1));
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        @(negedge clk);
        // Busy: scrambled request lines must be ignored.
        req_valid = 1'b0;
        req_op    = 2'($urandom_range(0, 3));
        req_a     = $urandom;
        req_b     = $urandom;
        check("lo_alu_drive", 96'({alu_a, alu_b, alu_s, alu_cin}),
              96'({a[15:0], b[15:0], op, op[0] ? m_flags[1] : 1'b0}));
        check("lo_busy", 96'({req_ready, rsp_valid}), 96'(0));
        @(negedge clk);
        check("hi_alu_drive", 96'({alu_a, alu_b, alu_s, alu_cin}),
              96'({a[31:16], b[31:16], op[1] ? 2'b11 : 2'b01, lo_sum[16]}));
        check("hi_flags_unchanged", 96'(flags), 96'(m_flags));
        @(negedge clk);
        check("rsp_valid_latency", 96'(rsp_valid), 96'(1));
        check("rsp_result", 96'(rsp_result), 96'(exp[35:4]));
        check("rsp_nzcv", 96'(rsp_nzcv), 96'(exp[3:0]));
        check("flags_loaded", 96'(flags), 96'(exp[3:0]));
        if (chk_lit) check("directed_value", 96'({rsp_result, rsp_nzcv}), 96'(lit));
        m_flags = exp[3:0];
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_rsp", 96'({rsp_valid, req_ready, rsp_result, rsp_nzcv}),
                  96'({2'b10, exp}));
            check("hold_alu_idle", 96'({alu_a, alu_b, alu_s, alu_cin}), 96'(0));
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("after_handshake", 96'({rsp_valid, req_ready}), 96'(2'b01));
    endtask

    initial begin
        logic [31:0] edge_vals [4];
        logic [31:0] a, b;
        edge_vals[0] = 32'h0000_0000;
        edge_vals[1] = 32'hFFFF_FFFF;
        edge_vals[2] = 32'h7FFF_FFFF;
        edge_vals[3] = 32'h0000_FFFF;

        rst       = 1'b0;
        req_valid = 1'b0;
        req_op    = 2'b00;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        m_flags   = 4'h0;
        #1 rst = 1'b1;
        #2;
        check("reset_state", 96'({req_ready, rsp_valid, rsp_result, rsp_nzcv, flags}),
              96'({2'b10, 40'h0}));
        check("reset_alu", 96'({alu_a, alu_b, alu_s, alu_cin}), 96'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_op(2'b00, 32'h0000_FFFF, 32'h0000_0001, 0, 1'b1, {32'h0001_0000, 4'b0000});
        run_op(2'b10, 32'h0000_0000, 32'h0000_0001, 0, 1'b1, {32'hFFFF_FFFF, 4'b1000});
        run_op(2'b00, 32'h7FFF_FFFF, 32'h0000_0001, 0, 1'b1, {32'h8000_0000, 4'b1001});
        run_op(2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 0, 1'b1, {32'h0000_0000, 4'b0110});
        run_op(2'b10, 32'h1234_5678, 32'h1234_5678, 0, 1'b1, {32'h0000_0000, 4'b0110});
        run_op(2'b01, 32'h0000_0000, 32'h0000_0000, 0, 1'b1, {32'h0000_0001, 4'b0000});
        run_op(2'b10, 32'h0001_0000, 32'h0000_0001, 5, 1'b1, {32'h0000_FFFF, 4'b0010});

        // Reset during the high pass: immediate clear, no response afterwards.
        req_valid = 1'b1;
        req_op    = 2'b00;
        req_a     = 32'hFFFF_FFFF;
        req_b     = 32'h0000_0001;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_reset_state", 96'({req_ready, rsp_valid, rsp_result, rsp_nzcv, flags}),
              96'({2'b10, 40'h0}));
        check("mid_reset_alu", 96'({alu_a, alu_b, alu_s, alu_cin}), 96'(0));
        @(negedge clk);
        rst     = 1'b0;
        m_flags = 4'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("no_rsp_after_reset", 96'({rsp_valid, req_ready, flags}), 96'(5'b01_0000));
        end
        run_op(2'b00, 32'd2, 32'd3, 0, 1'b1, {32'd5, 4'b0000});

        for (int i = 0; i < 60; i++) begin
            a = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 3)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 3)] : $urandom;
            run_op(2'($urandom_range(0, 3)), a, b, int'($urandom_range(0, 2)), 1'b0, 36'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/alu_seq32.md
# alu_seq32

Two-pass 32-bit arithmetic sequencer that sits in front of the 16-bit ripple-carry ALU and drives its operand/select/carry-in port. It accepts one 32-bit add/subtract request per transaction on a valid/ready interface. It runs the ALU twice: low half first, then high half with the captured carry chained in. It returns the 32-bit result plus full-width N/Z/C/V on a valid/ready response channel and keeps an architectural NZCV register for carry-chained operations.

## Interface
Parameters: none (widths fixed at 32-bit request, 16-bit ALU).

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept (IDLE only)
- req_op  in  2  00 ADD, 01 ADC, 10 SUB, 11 SBC
- req_a, req_b  in  32  operands
- alu_a, alu_b  out  16  ALU operands
- alu_s  out  2  ALU select (00 A+B, 01 A+B+Cin, 10 A-B, 11 A+~B+Cin)
- alu_cin  out  1  ALU carry-in
- alu_result  in  16  ALU sum
- alu_n, alu_z, alu_c, alu_v  in  1  ALU flags
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts
- rsp_result  out  32  result
- rsp_nzcv  out  4  {N,Z,C,V} of this operation
- flags  out  4  architectural NZCV register

## Operation
- States: IDLE, LO, HI, RESP.
- IDLE: req_ready=1. When req_valid&&req_ready, latch op/a/b and go to LO.
- LO: drive alu_a=a[15:0], alu_b=b[15:0].
  - ADD: S=00, cin=0. SUB: S=10, cin=0.
  - ADC: S=01, cin=flags.C. SBC: S=11, cin=flags.C.
  - Capture lo_res=alu_result, lo_z=alu_z, lo_c=alu_c. Go to HI.
- HI: drive alu_a=a[31:16], alu_b=b[31:16], alu_cin=lo_c.
  - S=01 for ADD/ADC; S=11 for SUB/SBC.
  - Capture rsp_result={alu_result,lo_res}, N=alu_n, Z=lo_z&alu_z, C=alu_c, V=alu_v. Load the same value into flags. Go to RESP.
- RESP: rsp_valid=1 and outputs stable until rsp_ready. On handshake, go to IDLE.
- C semantics: carry out for add. For subtract, C=1 means no borrow.
- Outside LO/HI, alu_a/alu_b/alu_s/alu_cin are driven 0.

## Timing
- Reset, asynchronous and immediate:
  - state=IDLE, req_ready=1, rsp_valid=0.
  - rsp_result=0, rsp_nzcv=0, flags=0, all alu_* outputs 0.
- Reset mid-operation aborts the transaction with no response, and flags return to 0.
- Request accepted at edge T:
  - LO is active during cycle T+1.
  - HI is active during cycle T+2.
  - rsp_valid is high from T+3.
  - Minimum latency is 3 cycles; throughput is 1 op per 4 cycles.
- The ALU path is combinational. Sampling alu_* inputs in the same cycle the sequencer drives alu_* outputs is required.
- No request is accepted while busy. req_* values are ignored outside IDLE.
- If rsp_ready is high on the first RESP cycle, the handshake completes. The next request can be accepted one cycle later, in IDLE.
- flags update exactly once per operation, at the HI→RESP edge. They are not updated on LO.

## Configuration
- ALU_SEQ_SHORT16_EN defined:
  - Adds input req_w16 (1 bit, latched with the request).
  - When req_w16=1, LO→RESP directly and HI is skipped. Latency is 2.
  - rsp_result={16'h0,lo_res}. N/Z/C/V come from the LO pass and flags load from LO.
- ALU_SEQ_SHORT16_EN undefined: port absent; every operation is 32-bit.

## Structure
- Shared package alu_seq_pkg holds:
  - op codes (ADD/ADC/SUB/SBC)
  - ALU select constants (S_ADD, S_ADC, S_SUB, S_SBC)
  - state enum typedef
  - NZCV bit-index constants
- Single module; no sub-module needed. The 16-bit ALU is instantiated beside it at the top level, not inside.

## Test plan
- ADD 0x0000_FFFF+0x0000_0001 → rsp_result 0x0001_0000, NZCV 0000; rsp_valid 3 cycles after accept.
- SUB 0x0000_0000−0x0000_0001 → 0xFFFF_FFFF, NZCV 1000 (borrow, C=0); flags=1000.
- ADD 0x7FFF_FFFF+0x0000_0001 → 0x8000_0000, NZCV 1001; ADD 0xFFFF_FFFF+1 → 0, NZCV 0110.
- SUB 0x1234_5678−0x1234_5678 → 0, NZCV 0110 (C=1). Then ADC 0+0 → 0x0000_0001 using stored C.
- Hold rsp_ready low 5 cycles → response stable, req_ready=0, alu_* = 0. Release → next request accepted the following cycle.
- Assert rst during HI → all outputs 0 immediately, flags 0, no response. After release, ADD 2+3 → 5.
